led_pattern_gen: RTL and testbench

Parametrised multi-channel LED driver, successor to the fixed single-channel blinker in the FPGA fabric. Each channel runs its own period counter and can be set at runtime to off, on, blink, fixed-duty PWM, or breathe. Configuration arrives on a simple single-cycle write port driven from the fabric. Outputs drive the board LED pins (red/green/blue on the default 3-channel build).

---
 rtl/led_pattern_gen.sv | 189 ++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Multi-channel LED pattern driver. Each channel has its own
//            period counter and runs in one of OFF / ON / BLINK / PWM /
//            BREATHE, selected at runtime via a single-cycle write port.
//            Period and duty writes land in shadow registers and are
//            adopted at the channel's next period boundary.
// Ports    : clk          - fabric clock
//            rst_n        - asynchronous active-low reset
//            cfg_wr       - write strobe (one write per high cycle)
//            cfg_ch       - target channel index
//            cfg_sel      - 0 mode, 1 period, 2 duty, 3 reserved
//            cfg_data     - write data (mode [2:0], duty [PWM_W-1:0])
//            led_out      - registered LED drive, bit i = channel i
//            period_tick  - one-cycle pulse at each channel period boundary
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int NUM_CH         = 3,
  parameter int CNT_W          = 24,
  parameter int PWM_W          = 8,
  parameter int DEFAULT_PERIOD = 8000000,
  parameter int RESET_MODE     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] led_out,
  output logic [NUM_CH-1:0] period_tick
);

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_e;

  localparam logic [1:0]       C_SEL_MODE   = 2'd0;
  localparam logic [1:0]       C_SEL_PERIOD = 2'd1;
  localparam logic [1:0]       C_SEL_DUTY   = 2'd2;
  localparam logic [1:0]       C_SEL_RSVD   = 2'd3;
  localparam logic [CNT_W-1:0] C_DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [2:0]       C_RST_MODE   = 3'(RESET_MODE);
  localparam logic [PWM_W-1:0] C_DUTY_MAX   = {PWM_W{1'b1}};

  // A write is only acted on when it addresses an existing channel and a
  // defined register; anything else is dropped without side effects.
  logic w_wr_ok;
  assign w_wr_ok = cfg_wr && (cfg_sel != C_SEL_RSVD) &&
                   ({29'd0, cfg_ch} < 32'(NUM_CH));

  // Shared free-running PWM phase counter.
  logic [PWM_W-1:0] pwm_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [2:0]       mode_q,      mode_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] per_act_q,   per_act_d;
    logic [CNT_W-1:0] per_shd_q,   per_shd_d;
    logic [PWM_W-1:0] duty_act_q,  duty_act_d;
    logic [PWM_W-1:0] duty_shd_q,  duty_shd_d;
    logic             dir_up_q,    dir_up_d;
    logic             duty_pend_q, duty_pend_d;
    logic             led_q,       led_d;
    logic             tick_q,      tick_d;
    logic             w_hit, w_wr_mode, w_wr_per, w_wr_duty, w_bnd;

    assign w_hit     = w_wr_ok && (cfg_ch == 3'(i));
    assign w_wr_mode = w_hit && (cfg_sel == C_SEL_MODE);
    assign w_wr_per  = w_hit && (cfg_sel == C_SEL_PERIOD);
    assign w_wr_duty = w_hit && (cfg_sel == C_SEL_DUTY);
    assign w_bnd     = (cnt_q == per_act_q);

    always_comb begin
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      per_act_d   = per_act_q;
      per_shd_d   = per_shd_q;
      duty_act_d  = duty_act_q;
      duty_shd_d  = duty_shd_q;
      dir_up_d    = dir_up_q;
      duty_pend_d = duty_pend_q;
      led_d       = led_q;
      tick_d      = 1'b0;

      if (w_wr_mode) begin
        // Mode change restarts the channel and suppresses any boundary
        // that happens to coincide with it.
        mode_d   = cfg_data[2:0];
        cnt_d    = '0;
        led_d    = 1'b0;
        dir_up_d = 1'b1;
      end else begin
        case (mode_q)
          MODE_ON:      led_d = 1'b1;
          MODE_BLINK:   led_d = w_bnd ? ~led_q : led_q;
          MODE_PWM,
          MODE_BREATHE: led_d = (pwm_cnt_q < duty_act_q);
          default:      led_d = 1'b0;
        endcase

        tick_d = w_bnd;
        if (w_bnd) begin
          cnt_d       = '0;
          per_act_d   = per_shd_q;
          duty_pend_d = 1'b0;
          if (mode_q == MODE_PWM) begin
            duty_act_d = duty_shd_q;
          end else if (mode_q == MODE_BREATHE) begin
            if (duty_pend_q) begin
              // A duty written while breathing re-seats the ramp point.
              duty_act_d = duty_shd_q;
            end else if (dir_up_q) begin
              if (duty_act_q == C_DUTY_MAX) begin
                dir_up_d   = 1'b0;
                duty_act_d = duty_act_q - PWM_W'(1);
              end else begin
                duty_act_d = duty_act_q + PWM_W'(1);
              end
            end else begin
              if (duty_act_q == '0) begin
                dir_up_d   = 1'b1;
                duty_act_d = PWM_W'(1);
              end else begin
                duty_act_d = duty_act_q - PWM_W'(1);
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Shadow writes come last so a write on a boundary cycle is kept
      // for the following boundary rather than being consumed now.
      if (w_wr_per) begin
        per_shd_d = cfg_data;
      end
      if (w_wr_duty) begin
        duty_shd_d  = cfg_data[PWM_W-1:0];
        duty_pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q      <= C_RST_MODE;
        cnt_q       <= '0;
        per_act_q   <= C_DEF_PERIOD;
        per_shd_q   <= C_DEF_PERIOD;
        duty_act_q  <= '0;
        duty_shd_q  <= '0;
        dir_up_q    <= 1'b1;
        duty_pend_q <= 1'b0;
        led_q       <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        mode_q      <= mode_d;
        cnt_q       <= cnt_d;
        per_act_q   <= per_act_d;
        per_shd_q   <= per_shd_d;
        duty_act_q  <= duty_act_d;
        duty_shd_q  <= duty_shd_d;
        dir_up_q    <= dir_up_d;
        duty_pend_q <= duty_pend_d;
        led_q       <= led_d;
        tick_q      <= tick_d;
      end
    end

    assign led_out[i]     = led_q;
    assign period_tick[i] = tick_q;
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Self-checking bench for led_pattern_gen (3 channels,
//            DEFAULT_PERIOD = 9). Hand-derived vector table for the blink
//            and boundary cases, plus a cycle-level reference model for
//            PWM, breathe and randomized write traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  localparam int NCH   = 3;
  localparam int CW    = 16;
  localparam int PW    = 8;
  localparam int DPER  = 9;
  localparam int DMAX  = (1 << PW) - 1;

  logic          clk;
  logic          rst_n;
  logic          cfg_wr;
  logic [2:0]    cfg_ch;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic [NCH-1:0] led_out;
  logic [NCH-1:0] period_tick;

  led_pattern_gen #(
    .NUM_CH(NCH), .CNT_W(CW), .PWM_W(PW),
    .DEFAULT_PERIOD(DPER), .RESET_MODE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .led_out(led_out), .period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int edge_n = 0;

  // ---------------- reference model (spec-level, integer arithmetic) -----
  int m_mode[NCH], m_cnt[NCH], m_pact[NCH], m_pshd[NCH];
  int m_dact[NCH], m_dshd[NCH], m_dir[NCH];
  bit m_pend[NCH], m_led[NCH], m_tick[NCH];
  int m_pwm;

  task automatic model_reset();
    m_pwm = 0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 2; m_cnt[c] = 0; m_pact[c] = DPER; m_pshd[c] = DPER;
      m_dact[c] = 0; m_dshd[c] = 0; m_dir[c] = 1; m_pend[c] = 0;
      m_led[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_step(input bit wr, input int ch, input int sel, input int data);
    int phase;
    phase = m_pwm;
    m_pwm = (m_pwm + 1) % (DMAX + 1);
    for (int c = 0; c < NCH; c++) begin
      bit hit, at_end;
      hit    = wr && (ch == c) && (sel != 3);
      at_end = (m_cnt[c] == m_pact[c]);
      if (hit && sel == 0) begin
        m_mode[c] = data % 8; m_cnt[c] = 0; m_led[c] = 0; m_dir[c] = 1; m_tick[c] = 0;
      end else begin
        case (m_mode[c])
          1:       m_led[c] = 1;
          2:       if (at_end) m_led[c] = !m_led[c];
          3, 4:    m_led[c] = (phase < m_dact[c]);
          default: m_led[c] = 0;
        endcase
        m_tick[c] = at_end;
        if (at_end) begin
          m_cnt[c]  = 0;
          m_pact[c] = m_pshd[c];
          if (m_mode[c] == 3) begin
            m_dact[c] = m_dshd[c];
          end else if (m_mode[c] == 4) begin
            if (m_pend[c]) begin
              m_dact[c] = m_dshd[c];
            end else begin
              if (m_dact[c] + m_dir[c] > DMAX || m_dact[c] + m_dir[c] < 0)
                m_dir[c] = -m_dir[c];
              m_dact[c] = m_dact[c] + m_dir[c];
            end
          end
          m_pend[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      if (hit && sel == 1) m_pshd[c] = data;
      if (hit && sel == 2) begin m_dshd[c] = data % (DMAX + 1); m_pend[c] = 1; end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check3(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT sees on this edge,
  // then compare both outputs just after the edge. Writes are one-cycle.
  task automatic step();
    logic [NCH-1:0] el, et;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(cfg_wr, int'(cfg_ch), int'(cfg_sel), int'(cfg_data));
    edge_n++;
    #1;
    for (int c = 0; c < NCH; c++) begin
      el[c] = m_led[c];
      et[c] = m_tick[c];
    end
    check3($sformatf("model_led@%0d", edge_n), led_out, el);
    check3($sformatf("model_tick@%0d", edge_n), period_tick, et);
    cfg_wr = 1'b0;
  endtask

  task automatic set_wr(input int ch, input int sel, input int data);
    cfg_wr   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = CW'(data);
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 100000 && edge_n < target; k++) step();
  endtask

  // ---------------- hand-derived vector table ----------------
  typedef struct {
    int             edge_no;
    bit             do_wr;
    int             ch;
    int             sel;
    int             data;
    logic [NCH-1:0] led;
    logic [NCH-1:0] tick;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int ones;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    rst_n = 1'b0;
    model_reset();

    // edge, write?, ch, sel, data, expected led, expected tick
    tbl[0]  = '{ 9, 1'b0, 0, 0, 0, 3'b000, 3'b000};
    tbl[1]  = '{10, 1'b0, 0, 0, 0, 3'b111, 3'b111};
    tbl[2]  = '{11, 1'b0, 0, 0, 0, 3'b111, 3'b000};
    tbl[3]  = '{20, 1'b0, 0, 0, 0, 3'b000, 3'b111};
    tbl[4]  = '{30, 1'b0, 0, 0, 0, 3'b111, 3'b111};
    tbl[5]  = '{35, 1'b1, 1, 1, 3, 3'b111, 3'b000};  // ch1 period <- 3 at cnt 5
    tbl[6]  = '{40, 1'b0, 0, 0, 0, 3'b000, 3'b111};
    tbl[7]  = '{44, 1'b0, 0, 0, 0, 3'b010, 3'b010};
    tbl[8]  = '{48, 1'b0, 0, 0, 0, 3'b000, 3'b010};
    tbl[9]  = '{50, 1'b0, 0, 0, 0, 3'b101, 3'b101};
    tbl[10] = '{52, 1'b0, 0, 0, 0, 3'b111, 3'b010};
    tbl[11] = '{69, 1'b1, 0, 0, 2, 3'b010, 3'b000};  // mode write lands on ch0 boundary
    tbl[12] = '{70, 1'b0, 0, 0, 0, 3'b110, 3'b100};
    tbl[13] = '{80, 1'b0, 0, 0, 0, 3'b001, 3'b111};

    repeat (3) step();
    rst_n  = 1'b1;
    edge_n = 0;
    check3("reset_led", led_out, 3'b000);
    check3("reset_tick", period_tick, 3'b000);

    for (int k = 0; k < 14; k++) begin
      run_to(tbl[k].edge_no);
      check3($sformatf("tbl%0d_led@%0d", k, tbl[k].edge_no), led_out, tbl[k].led);
      check3($sformatf("tbl%0d_tick@%0d", k, tbl[k].edge_no), period_tick, tbl[k].tick);
      if (tbl[k].do_wr) set_wr(tbl[k].ch, tbl[k].sel, tbl[k].data);
    end

    // ---- PWM on ch0: duty 64 then 0, period 0 ----
    set_wr(0, 0, 3);  step();
    set_wr(0, 2, 64); step();
    set_wr(0, 1, 0);  step();
    repeat (15) step();
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      ones += int'(led_out[0]);
    end
    check_int("pwm_duty64_on_cycles", ones, 64);

    set_wr(0, 2, 0); step();
    repeat (3) step();
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      ones += int'(led_out[0]);
    end
    check_int("pwm_duty0_on_cycles", ones, 0);

    // ---- BREATHE on ch2 with period 0, tracked by the model ----
    set_wr(2, 0, 4); step();
    set_wr(2, 1, 0); step();
    repeat (700) step();

    // ---- writes to a non-existent channel and to the reserved register ----
    set_wr(5, 0, 0); step();
    set_wr(1, 3, 0); step();
    repeat (20) step();

    // ---- randomized write traffic ----
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) < 3) begin
        int sel, ch, data;
        ch  = $urandom_range(0, 7) < 6 ? $urandom_range(0, NCH - 1) : $urandom_range(3, 7);
        sel = $urandom_range(0, 3);
        case (sel)
          0:       data = $urandom_range(0, 7);
          1:       data = $urandom_range(0, 20);
          2:       data = $urandom_range(0, DMAX);
          default: data = $urandom_range(0, 65535);
        endcase
        set_wr(ch, sel, data);
      end
      step();
    end

    // ---- asynchronous reset in the middle of BLINK with all LEDs lit ----
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    edge_n = 0;
    run_to(12);
    check3("blink_all_lit", led_out, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check3("async_rst_led", led_out, 3'b000);
    check3("async_rst_tick", period_tick, 3'b000);
    model_reset();
    step();
    rst_n  = 1'b1;
    edge_n = 0;
    run_to(9);
    check3("post_rst_led@9", led_out, 3'b000);
    run_to(10);
    check3("post_rst_led@10", led_out, 3'b111);
    check3("post_rst_tick@10", period_tick, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
